// File: rtl/mips_step_ctrl_if.sv
// Board-side bundle for the MIPS run/step controller: buttons, mode and
// breakpoint controls in, step enable and display status out.
interface mips_step_ctrl_if #(
  parameter int NBTN = 3,
  parameter int PCW  = 32
);
  logic [NBTN-1:0] nBTN;
  logic [1:0]      MODE;
  logic            BP_EN;
  logic [PCW-1:0]  BP_ADDR;
  logic [PCW-1:0]  PC;
  logic [NBTN-1:0] BTN_PULSE;
  logic            STEP_EN;
  logic [15:0]     STEP_CNT;
  logic [1:0]      STATE;
  logic            BP_HIT;

  // Board / CPU side that drives the controls and watches the results
  modport master (
    output nBTN, MODE, BP_EN, BP_ADDR, PC,
    input  BTN_PULSE, STEP_EN, STEP_CNT, STATE, BP_HIT
  );

  // The controller itself
  modport slave (
    input  nBTN, MODE, BP_EN, BP_ADDR, PC,
    output BTN_PULSE, STEP_EN, STEP_CNT, STATE, BP_HIT
  );
endinterface

// File: rtl/mips_step_ctrl.sv
// Run/step controller for the single-clock MIPS: debounces the board
// buttons and generates the CPU clock-enable as single steps, fixed bursts
// or a divided free-run, halting bursts/runs on a PC breakpoint.
module mips_step_ctrl #(
  parameter int NBTN      = 3,
  parameter int DB_CYCLES = 16,
  parameter int BURST_LEN = 8,
  parameter int RUN_DIV   = 4,
  parameter int PCW       = 32
) (
  input logic CLK,
  input logic RST,
  mips_step_ctrl_if.slave bus
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam int BLW = $clog2(BURST_LEN + 1);
  localparam int DVW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_RUN   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  logic [NBTN-1:0] sync1;
  logic [NBTN-1:0] sync2;
  logic [NBTN-1:0] level;
  logic [NBTN-1:0] level_d;
  logic [NBTN-1:0] pulse;
  logic [DBW-1:0]  db_cnt [NBTN];

  state_t          state;
  logic            step_en;
  logic            bp_hit;
  logic [BLW-1:0]  remaining;
  logic [DVW-1:0]  div;
  logic [15:0]     step_cnt;

  logic            go;
  logic            stop;
  logic            bp_match;

  // STOP wins a same-cycle collision, so GO is masked by it
  assign stop     = pulse[1];
  assign go       = pulse[0] & ~pulse[1];
  assign bp_match = bus.BP_EN && (bus.PC == bus.BP_ADDR);

  // Synchronise, debounce, and turn each accepted press into a one-cycle pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      pulse   <= '0;
      for (int i = 0; i < NBTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1   <= ~bus.nBTN;
      sync2   <= sync1;
      level_d <= level;
      pulse   <= level & ~level_d;
      for (int i = 0; i < NBTN; i++) begin
        if (sync2[i] != level[i]) begin
          if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
            level[i]  <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Step FSM: decide each cycle, present STEP_EN and BP_HIT one cycle later
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      step_en   <= 1'b0;
      bp_hit    <= 1'b0;
      remaining <= '0;
      div       <= '0;
    end else begin
      step_en <= 1'b0;
      bp_hit  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            case (bus.MODE)
              2'b00: step_en <= 1'b1;
              2'b01: begin
                remaining <= BLW'(BURST_LEN);
                state     <= S_BURST;
              end
              2'b10: begin
                div   <= '0;
                state <= S_RUN;
              end
              default: ;
            endcase
          end
        end
        S_BURST: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (bp_match) begin
            state  <= S_HALT;
            bp_hit <= 1'b1;
          end else begin
            step_en   <= 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == BLW'(1)) begin
              state <= S_IDLE;
            end
          end
        end
        S_RUN: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (bp_match) begin
            state  <= S_HALT;
            bp_hit <= 1'b1;
          end else if (div == DVW'(RUN_DIV - 1)) begin
            step_en <= 1'b1;
            div     <= '0;
          end else begin
            div <= div + 1'b1;
          end
        end
        S_HALT: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (go) begin
            step_en <= 1'b1;
            state   <= S_IDLE;
          end else begin
            bp_hit <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Running count of issued steps for the display; wraps naturally
  always_ff @(posedge CLK) begin
    if (RST) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + {15'd0, step_en};
    end
  end

  assign bus.BTN_PULSE = pulse;
  assign bus.STEP_EN   = step_en;
  assign bus.STEP_CNT  = step_cnt;
  assign bus.STATE     = state;
  assign bus.BP_HIT    = bp_hit;

endmodule

// File: doc/mips_step_ctrl.md
Name: mips_step_ctrl

Overview:
Parametrised run/step controller for the single-clock MIPS on the FPGA board.
- Debounces NBTN raw active-low buttons and emits one-cycle press pulses.
- Produces a one-cycle CPU clock-enable (STEP_EN) in four ways: single-step, fixed-length burst, free-run at a divided rate, and a PC breakpoint that halts burst/run.
- Sits between board buttons/switches and the CPU's clock-enable input; also exports step count and state for the 7-seg/LED display.

Parameters:
NBTN, 3, number of raw buttons debounced (>=2; bit0 = GO, bit1 = STOP, rest pass-through pulses only)
DB_CYCLES, 16, consecutive stable synchronised samples required to accept a new button level (>=2)
BURST_LEN, 8, steps issued per burst (>=1)
RUN_DIV, 4, free-run period in CLK cycles between STEP_EN pulses (>=1; 1 = every cycle)
PCW, 32, PC / breakpoint address width

Ports:
CLK  in  1  system clock
RST  in  1  reset, synchronous to CLK, active-high
nBTN  in  NBTN  raw buttons, active-low, asynchronous
MODE  in  2  00 step, 01 burst, 10 run, 11 hold (GO ignored)
BP_EN  in  1  breakpoint enable
BP_ADDR  in  PCW  breakpoint PC
PC  in  PCW  current CPU PC
BTN_PULSE  out  NBTN  debounced press pulses, one cycle each
STEP_EN  out  1  CPU clock-enable, one cycle per step
STEP_CNT  out  16  total steps issued
STATE  out  2  0 IDLE, 1 BURST, 2 RUN, 3 HALT
BP_HIT  out  1  high while in HALT

Behaviour:
- Reset (RST high at a CLK edge): state IDLE; all outputs 0; debounced levels = released; sync flops, debounce counters, burst and divider counters cleared. Reset mid-burst or mid-run aborts with no further STEP_EN.
- Debounce, per button:
  - 2-FF synchroniser on ~nBTN.
  - Counter runs while the synchronised value differs from the debounced level and clears on any agreement (bounce).
  - After DB_CYCLES consecutive differing samples, the debounced level updates.
  - BTN_PULSE[i] is high for exactly one cycle on a released->pressed update. No pulse on release.
  - Latency from the first edge sampling a stable press to BTN_PULSE = DB_CYCLES+2 cycles.
- GO = BTN_PULSE[0], STOP = BTN_PULSE[1]. If both occur in the same cycle, STOP wins and GO is discarded.
- FSM, evaluated each cycle; STEP_EN is registered, asserted in the cycle after the decision:
  - IDLE:
    - GO with MODE=00: one STEP_EN, stay IDLE.
    - GO with MODE=01: load remaining=BURST_LEN, go to BURST.
    - GO with MODE=10: clear divider, go to RUN.
    - MODE=11: GO ignored.
    - Breakpoint not checked in IDLE, so single-step can pass a breakpoint.
  - BURST:
    - Priority: STOP > breakpoint > step.
    - STOP: go to IDLE, no step.
    - BP_EN and PC==BP_ADDR: go to HALT, no step.
    - Otherwise issue a step and decrement remaining. When remaining reaches 0, return to IDLE. Exactly BURST_LEN consecutive STEP_EN pulses if uninterrupted.
  - RUN:
    - Same priority as BURST.
    - Step issued when the divider hits RUN_DIV-1; divider wraps to 0.
    - First STEP_EN occurs RUN_DIV cycles after entry; pulses are spaced RUN_DIV cycles apart. Runs indefinitely.
  - HALT:
    - BP_HIT=1.
    - GO: issue exactly one STEP_EN, go to IDLE (step past breakpoint).
    - STOP: go to IDLE, no step.
- MODE changes outside IDLE are ignored until the next IDLE decision.
- STEP_CNT increments by 1 in every cycle STEP_EN=1 and wraps 0xFFFF->0x0000.
- PC is sampled combinationally each cycle. The CPU advances PC only on STEP_EN, so a match is seen before the next step issues.

Test Plan:
All scenarios use DB_CYCLES=4, BURST_LEN=8, RUN_DIV=4.
1. Reset release; nBTN[0] low with a 1-cycle bounce high at cycle 2, then stable -> BTN_PULSE[0] only 6 cycles after the bounce ends, one cycle wide; no pulse on release.
2. MODE=00, three GO presses -> three single-cycle STEP_EN pulses; STEP_CNT=3; STATE stays 0.
3. MODE=01, GO, BP_EN=0 -> 8 back-to-back STEP_EN pulses, STATE 1 then 0, STEP_CNT +8. Repeat with STOP after the 3rd step -> exactly 3 steps, STATE=0.
4. MODE=10, GO, PC stepping 0x00,0x04,...; BP_EN=1, BP_ADDR=0x10 -> STEP_EN every 4 cycles; STATE=3 and BP_HIT=1 once PC=0x10, with no further steps. Then GO -> exactly one STEP_EN, STATE=0, BP_HIT=0.
5. GO and STOP pulses in the same cycle while in RUN -> IDLE, no STEP_EN. Same in IDLE with MODE=01 -> remains IDLE, no burst.
6. STEP_CNT preloaded near wrap via 0xFFFE steps (or forced) plus 3 steps -> reads 0x0001. RST asserted mid-burst -> STEP_EN=0 the next cycle, all outputs 0.
